// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store request stage.
// Optional misaligned-access splitting is enabled with LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] LANE_B0  = 4'b0001;
  localparam logic [3:0] LANE_B1  = 4'b0010;
  localparam logic [3:0] LANE_B2  = 4'b0100;
  localparam logic [3:0] LANE_B3  = 4'b1000;
  localparam logic [3:0] LANE_HLO = 4'b0011;
  localparam logic [3:0] LANE_HHI = 4'b1100;
  localparam logic [3:0] LANE_W   = 4'b1111;

  localparam int unsigned RMEM_SIGNED = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} lsu_state_e;

  function automatic logic [2:0] access_bytes(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(logic [2:0] f3, logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'b0, d[7:0]};
      2'b01:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_decode.sv
// Combinational decode of width code and byte offset into memory lane codes
// plus misalignment / illegal-encoding flags.
module lsu_lane_decode
  import lsu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic [3:0] wmem,
  output logic [4:0] rmem,
  output logic       misalign,
  output logic       illegal
);

  logic [3:0] lanes;
  logic       sext;

  always_comb begin
    lanes    = 4'b0000;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_B, F3_BU: lanes = LANE_B0 << addr_lo;
      F3_H, F3_HU: begin
        lanes    = addr_lo[1] ? LANE_HHI : LANE_HLO;
        misalign = addr_lo[0];
      end
      F3_W: begin
        lanes    = LANE_W;
        misalign = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned widths exist only for loads.
    if (we && funct3[2]) illegal = 1'b1;
    sext = (funct3 == F3_B) || (funct3 == F3_H);
  end

  always_comb begin
    wmem = 4'b0000;
    rmem = 5'b00000;
    if (we) begin
      wmem = lanes;
    end else begin
      rmem[3:0]         = lanes;
      rmem[RMEM_SIGNED] = sext;
    end
  end

endmodule

// File: rtl/lsu_req_stage.sv
// Load/store request stage: IDLE -> ACCESS -> RESP, one memory access per request.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/W accesses into byte beats.
module lsu_req_stage
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  lsu_state_e  state_q, state_d;
  logic [3:0]  dec_wmem;
  logic [4:0]  dec_rmem;
  logic        dec_misalign, dec_illegal;
  logic        req_fire, range_err, req_err, acc_done;
  logic        we_q, err_q;
  logic [3:0]  wmem_q;
  logic [4:0]  rmem_q;
  logic [31:0] wdata_q, rdata_q, rdata_d;

  lsu_lane_decode u_decode (
    .funct3   (req_funct3),
    .addr_lo  (req_addr[1:0]),
    .we       (req_we),
    .wmem     (dec_wmem),
    .rmem     (dec_rmem),
    .misalign (dec_misalign),
    .illegal  (dec_illegal)
  );

  assign req_ready = rst_n && (state_q == StIdle);
  assign req_fire  = req_valid && req_ready;
  assign range_err = (req_addr[31:ADDR_WIDTH+2] != '0);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [32:0] last_byte;
  logic [31:0] addr_q, cur_addr, asm_q, asm_next;
  logic [2:0]  f3_q;
  logic [1:0]  beat_q, last_q;
  logic        split_q;
  logic [3:0]  beat_lane;
  logic [7:0]  beat_byte;

  assign last_byte = {1'b0, req_addr} + 33'(access_bytes(req_funct3) - 3'd1);
  assign req_err   = dec_illegal || range_err || (last_byte[32:ADDR_WIDTH+2] != '0);
  assign acc_done  = !split_q || (beat_q == last_q);
  assign cur_addr  = addr_q + {30'b0, beat_q};
  assign beat_lane = LANE_B0 << cur_addr[1:0];
  assign beat_byte = wdata_q[{beat_q, 3'b000} +: 8];

  always_comb begin
    asm_next                        = asm_q;
    asm_next[{beat_q, 3'b000} +: 8] = load_data[7:0];
  end

  always_comb begin
    rdata_d = load_data;
    if (err_q || we_q) begin
      rdata_d = 32'b0;
    end else if (split_q) begin
      rdata_d = asm_next;
      if (f3_q[0]) rdata_d = {{16{(f3_q == F3_H) & asm_next[15]}}, asm_next[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      split_q <= 1'b0;
      asm_q   <= '0;
    end else if (req_fire) begin
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      beat_q  <= '0;
      last_q  <= 2'(access_bytes(req_funct3) - 3'd1);
      split_q <= dec_misalign && !req_err;
      asm_q   <= '0;
    end else if (state_q == StAccess && split_q) begin
      asm_q <= asm_next;
      if (!acc_done) beat_q <= beat_q + 2'd1;
    end
  end
`else
  logic [29:0] widx_q;

  assign req_err  = dec_illegal || range_err || dec_misalign;
  assign acc_done = 1'b1;
  assign rdata_d  = (err_q || we_q) ? 32'b0 : load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        widx_q <= '0;
    else if (req_fire) widx_q <= req_addr[31:2];
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req_fire) state_d = StAccess;
      StAccess: if (acc_done) state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wmem_q  <= '0;
      rmem_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        we_q    <= req_we;
        err_q   <= req_err;
        wmem_q  <= dec_wmem;
        rmem_q  <= dec_rmem;
        wdata_q <= store_mask(req_funct3, req_wdata);
      end
      if (state_q == StAccess && acc_done) rdata_q <= rdata_d;
    end
  end

  // Memory strobes are decoded from state so an async reset kills them at once.
  always_comb begin
    wmem       = '0;
    rmem       = '0;
    mem_addr   = '0;
    store_data = '0;
    if (state_q == StAccess && !err_q) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        mem_addr = {2'b00, cur_addr[31:2]};
        if (we_q) begin
          wmem       = beat_lane;
          store_data = {24'b0, beat_byte};
        end else begin
          rmem = {1'b0, beat_lane};
        end
      end else begin
        mem_addr   = {2'b00, addr_q[31:2]};
        wmem       = wmem_q;
        rmem       = rmem_q;
        store_data = wdata_q;
      end
`else
      mem_addr   = {2'b00, widx_q};
      wmem       = wmem_q;
      rmem       = rmem_q;
      store_data = wdata_q;
`endif
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;

endmodule

// File: doc/lsu_req_stage.md
Name: lsu_req_stage

Overview:
- Load/store request stage directly upstream of the unified instruction/data memory.
- Accepts one byte-addressed load/store request per transaction from the execute stage via valid/ready.
- Decodes the request into the memory's word index, byte-lane write mask (wmem) and load code (rmem), drives them for one cycle, and returns a response via valid/ready.
- Detects misaligned, out-of-range and illegal requests and reports them as errors.

Parameters:
- ADDR_WIDTH, 12, memory word-index width; valid byte addresses are 0 .. 2^(ADDR_WIDTH+2)-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal request
- wmem  out  4  byte-lane write mask to memory
- rmem  out  5  load code to memory: bit4 = sign-extend, bits3:0 = lane mask
- mem_addr  out  32  word index (byte address >> 2)
- store_data  out  32  store data, right-justified
- load_data  in  32  memory read data, combinational, already shifted and extended

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while in reset; resp_valid=0, resp_err=0, resp_rdata=0, wmem=0, rmem=0, mem_addr=0, store_data=0. Any in-flight transaction is dropped and no response is issued.
- States: IDLE, ACCESS, RESP.
- req_ready = (state==IDLE).
- IDLE: on handshake, register the request, compute the error flag, and go to ACCESS.
- ACCESS (one cycle):
  - If no error: drive mem_addr = addr[31:2].
    - Loads: rmem = {signed, lane mask}.
    - Stores: wmem = lane mask, store_data = wdata masked to the access size.
  - Lane masks by size and offset: B at off k -> 1<<k; H at off 0 -> 0011, off 2 -> 1100; W -> 1111.
  - Capture load_data at the end of the cycle. Go to RESP.
  - If error: wmem=0 and rmem=0 (no memory side effect); go to RESP.
  - wmem/rmem are nonzero only in ACCESS.
- RESP: resp_valid=1 and all resp_* held stable until resp_ready; then return to IDLE.
- Latency: a request accepted at edge N has memory access in cycle N+1 and resp_valid from cycle N+2. Throughput is at most one request per 3 cycles.
- Error conditions:
  - H with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2] != 0.
  - funct3 in {011, 110, 111}.
  - Store with funct3[2]=1.
- resp_rdata = 0 when resp_err=1.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned H/W (in range, legal funct3) is not an error.
  - The block splits the access into 2 (H) or 4 (W) single-byte beats in ascending byte-address order, one beat per cycle in ACCESS. The address increments across word boundaries.
  - Load beats use unsigned rmem = {0, onehot}. Bytes are assembled in a register and sign/zero-extended per funct3 at the end.
  - Store beats use wmem = onehot, store_data = {24'b0, byte}.
  - Range check covers the last byte; if any byte is out of range, no beats are issued and an error is reported.
  - resp_valid is asserted the cycle after the final beat.
- Undefined: misaligned accesses report resp_err as above.

Decomposition:
- Package lsu_pkg:
  - funct3 constants.
  - Lane-mask constants (LANE_B0..B3, LANE_HLO, LANE_HHI, LANE_W).
  - RMEM_SIGNED bit position.
  - State enum typedef.
- Sub-module lsu_lane_decode: combinational; funct3 + addr[1:0] + we -> wmem/rmem codes + misalign/illegal flags.

Test Plan:
- LW addr 0x0000_0010, memory word 4 = 0xDEADBEEF -> cycle N+1 mem_addr=4, rmem=01111; resp_rdata=0xDEADBEEF, resp_err=0 at N+2.
- LB addr 0x0000_0007, word 1 = 0x80xxxxxx -> rmem=11000, resp_rdata=0xFFFFFF80. LBU at the same address -> rmem=01000, resp_rdata=0x00000080.
- SH addr 0x0000_0022, wdata 0x1234ABCD -> ACCESS cycle wmem=1100, mem_addr=8, store_data=0x0000ABCD; resp_valid with resp_rdata=0.
- LW addr 0x0000_0005:
  - Macro undefined -> wmem=rmem=0 throughout, resp_err=1.
  - Macro defined -> 4 beats: rmem 00010, 00100, 01000 at mem_addr 1, then 00001 at mem_addr 2; assembled word returned.
- Out of range: SW addr 0x0001_0000 (ADDR_WIDTH=12) -> resp_err=1, no wmem pulse. Illegal: funct3=011 -> resp_err=1.
- resp_ready held low 5 cycles -> resp_valid/rdata stable, req_ready=0. rst_n pulsed low during ACCESS -> wmem/rmem drop to 0 immediately, no response, req_ready=1 after release.
